// File: rtl/reg_file_if.sv
// Register-file access bus.
// Groups the write port, the two read ports and the debug write counter so
// that a CPU datapath (master) and the register file (slave) share one bundle.
//   regWrite   - write enable
//   writeReg   - destination register index
//   writeData  - data to store
//   readReg1/2 - read port indices
//   readData1/2- read port data (driven by the register file)
//   writeCount - committed writes since reset (driven by the register file)
interface reg_file_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [WIDTH-1:0]  writeData;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [WIDTH-1:0]  readData1;
  logic [WIDTH-1:0]  readData2;
  logic [15:0]       writeCount;

  modport master (
    output regWrite, writeReg, writeData, readReg1, readReg2,
    input  readData1, readData2, writeCount
  );

  modport slave (
    input  regWrite, writeReg, writeData, readReg1, readReg2,
    output readData1, readData2, writeCount
  );
endinterface

// File: rtl/reg_file.sv
// Two-read / one-write register file with a hard-wired zero register.
// Reads are combinational and forward a same-cycle write so a pipeline can
// consume a value in the cycle it is produced.
//   clk   - rising-edge clock for all state
//   reset - asynchronous, active-high; clears every register and the counter
//   bus   - reg_file_if slave modport (write port, two read ports, writeCount)
module reg_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic     clk,
  input  logic     reset,
  reg_file_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [NREGS];
  logic [15:0]      writeCount;
  logic             commit;
  logic             bypassEn;

  // A write only takes effect for a non-zero destination; register 0 is
  // never stored into and the counter ignores discarded writes.
  assign commit = bus.regWrite && (bus.writeReg != '0);

  // Forwarding is suppressed during reset so both ports read zero then.
  assign bypassEn = commit && !reset;

  // Storage and the committed-write counter. The counter wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      writeCount <= '0;
    end else if (commit) begin
      regs[bus.writeReg] <= bus.writeData;
      writeCount         <= writeCount + 16'd1;
    end
  end

  // Read port 1: zero register first, then same-cycle forwarding, then storage.
  always_comb begin
    bus.readData1 = '0;
    if (bus.readReg1 == '0) begin
      bus.readData1 = '0;
    end else if (bypassEn && (bus.readReg1 == bus.writeReg)) begin
      bus.readData1 = bus.writeData;
    end else begin
      bus.readData1 = regs[bus.readReg1];
    end
  end

  // Read port 2: same priority as port 1, evaluated independently.
  always_comb begin
    bus.readData2 = '0;
    if (bus.readReg2 == '0) begin
      bus.readData2 = '0;
    end else if (bypassEn && (bus.readReg2 == bus.writeReg)) begin
      bus.readData2 = bus.writeData;
    end else begin
      bus.readData2 = regs[bus.readReg2];
    end
  end

  assign bus.writeCount = writeCount;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file.
// A table of vectors drives the main read/write/forwarding behaviour; hand
// sequences cover reset, mid-cycle reset, the full sweep and counter wrap.
// Expected values are pushed to a scoreboard queue when stimulus is driven and
// popped when the outputs are sampled.
module tb_reg_file;
  logic clk;
  logic reset;

  reg_file_if #(.WIDTH(32), .ADDR_W(5)) bus ();

  reg_file #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] expRd1;
    logic [31:0] expRd2;
    logic [15:0] expCount;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [15:0] cnt;
    bit          chkRd;
    bit          chkCnt;
  } exp_t;

  exp_t  sb[$];
  vec_t  vecs[11];
  int    checks = 0;
  int    passed = 0;
  logic [31:0] model [32];

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic pushRd(input string name, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    e.name = name; e.rd1 = e1; e.rd2 = e2; e.cnt = '0; e.chkRd = 1'b1; e.chkCnt = 1'b0;
    sb.push_back(e);
  endtask

  task automatic pushCnt(input string name, input logic [15:0] c);
    exp_t e;
    e.name = name; e.rd1 = '0; e.rd2 = '0; e.cnt = c; e.chkRd = 1'b0; e.chkCnt = 1'b1;
    sb.push_back(e);
  endtask

  task automatic pushAll(input string name, input logic [31:0] e1, input logic [31:0] e2,
                         input logic [15:0] c);
    exp_t e;
    e.name = name; e.rd1 = e1; e.rd2 = e2; e.cnt = c; e.chkRd = 1'b1; e.chkCnt = 1'b1;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                               input logic [4:0] r1, input logic [4:0] r2);
    bus.regWrite  = rw;
    bus.writeReg  = wr;
    bus.writeData = wd;
    bus.readReg1  = r1;
    bus.readReg2  = r2;
  endtask

  // Pops the oldest expectation and compares the fields it asks for.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, expected at least 1");
    end else begin
      e = sb.pop_front();
      if (e.chkRd) begin
        compare({e.name, "_rd1"}, bus.readData1, e.rd1);
        compare({e.name, "_rd2"}, bus.readData2, e.rd2);
      end
      if (e.chkCnt) compare({e.name, "_cnt"}, {16'h0, bus.writeCount}, {16'h0, e.cnt});
    end
  endtask

  initial begin
    // Vector table: expected reads are the combinational values before the
    // edge; expected count is the value after the edge.
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
    vecs[1]  = '{1'b0, 5'd5, 32'h12345678, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
    vecs[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h00000000, 32'hDEADBEEF, 16'd1};
    vecs[3]  = '{1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h00000000, 32'h00000000, 16'd1};
    vecs[4]  = '{1'b1, 5'd7, 32'h11111111, 5'd3, 5'd7, 32'h00000000, 32'h11111111, 16'd2};
    vecs[5]  = '{1'b1, 5'd3, 32'h0000CAFE, 5'd7, 5'd0, 32'h11111111, 32'h00000000, 16'd3};
    vecs[6]  = '{1'b1, 5'd7, 32'hBABAFFFB, 5'd7, 5'd3, 32'hBABAFFFB, 32'h0000CAFE, 16'd4};
    vecs[7]  = '{1'b0, 5'd7, 32'h00000000, 5'd7, 5'd3, 32'hBABAFFFB, 32'h0000CAFE, 16'd4};
    vecs[8]  = '{1'b1, 5'd1, 32'h00000001, 5'd1, 5'd1, 32'h00000001, 32'h00000001, 16'd5};
    vecs[9]  = '{1'b1, 5'd1, 32'h00000002, 5'd1, 5'd7, 32'h00000002, 32'hBABAFFFB, 16'd6};
    vecs[10] = '{1'b0, 5'd1, 32'h00000003, 5'd1, 5'd1, 32'h00000002, 32'h00000002, 16'd6};

    // Reset with a write attempt present: nothing forwards, nothing counts.
    reset = 1'b0;
    applyStimulus(1'b1, 5'd5, 32'hAAAAAAAA, 5'd5, 5'd31);
    #1 reset = 1'b1;
    #1;
    pushAll("reset_async", 32'h0, 32'h0, 16'd0);
    checkOutput();
    @(posedge clk); #1;
    pushAll("reset_held_edge", 32'h0, 32'h0, 16'd0);
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 5'd5, 32'hAAAAAAAA, 5'd5, 5'd31);
    #1;
    pushAll("after_reset", 32'h0, 32'h0, 16'd0);
    checkOutput();
    @(posedge clk); #1;
    pushAll("after_reset_edge", 32'h0, 32'h0, 16'd0);
    checkOutput();

    // Table-driven main function.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].regWrite, vecs[i].writeReg, vecs[i].writeData,
                    vecs[i].readReg1, vecs[i].readReg2);
      pushRd($sformatf("vec%0d", i), vecs[i].expRd1, vecs[i].expRd2);
      pushCnt($sformatf("vec%0d", i), vecs[i].expCount);
      #1 checkOutput();
      @(posedge clk); #1 checkOutput();
    end

    // Reset asserted between edges while a write to r1 is pending.
    @(negedge clk);
    applyStimulus(1'b1, 5'd1, 32'h00000055, 5'd1, 5'd5);
    pushRd("midrst_pre", 32'h00000055, 32'hDEADBEEF);
    #1 checkOutput();
    #2 reset = 1'b1;
    #1;
    pushAll("midrst_immediate", 32'h0, 32'h0, 16'd0);
    checkOutput();
    @(posedge clk); #1;
    pushAll("midrst_edge", 32'h0, 32'h0, 16'd0);
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 5'd1, 32'h00000055, 5'd1, 5'd5);
    #1;
    pushAll("midrst_release", 32'h0, 32'h0, 16'd0);
    checkOutput();

    // First write after reset commits normally.
    @(negedge clk);
    applyStimulus(1'b1, 5'd9, 32'h00000099, 5'd9, 5'd1);
    pushRd("first_write_fwd", 32'h00000099, 32'h0);
    #1 checkOutput();
    @(posedge clk); #1;
    pushCnt("first_write", 16'd1);
    checkOutput();
    @(negedge clk);
    applyStimulus(1'b0, 5'd9, 32'h0, 5'd1, 5'd9);
    pushRd("first_write_read", 32'h0, 32'h00000099);
    #1 checkOutput();

    // Full sweep from a clean reset.
    @(negedge clk);
    reset = 1'b1;
    #1 reset = 1'b0;
    model[0] = '0;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      model[i] = 32'(i) * 32'h01010101;
      applyStimulus(1'b1, 5'(i), model[i], 5'd0, 5'd0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    pushCnt("sweep", 16'd31);
    checkOutput();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'hFFFFFFFF, 5'(i), 5'(31 - i));
      pushRd($sformatf("sweep_r%0d", i), model[i], model[31 - i]);
      #1 checkOutput();
    end

    // Drive the counter to its wrap point: 65504 more writes reach 16'hFFFF.
    for (int n = 0; n < 65504; n++) begin
      @(negedge clk);
      applyStimulus(1'b1, 5'((n % 31) + 1), 32'(n), 5'd0, 5'd0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    pushCnt("count_max", 16'hFFFF);
    checkOutput();
    @(negedge clk);
    applyStimulus(1'b1, 5'd4, 32'h44444444, 5'd4, 5'd0);
    @(posedge clk); #1;
    pushCnt("count_wrap", 16'h0000);
    checkOutput();
    @(negedge clk);
    applyStimulus(1'b0, 5'd4, 32'h0, 5'd4, 5'd0);
    pushRd("wrap_write_read", 32'h44444444, 32'h0);
    #1 checkOutput();

    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
